// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC job sequencer.
// FSM states, job modes, ECC register addresses, write slots, status codes.
package ecc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT_DONE,
    ST_RESP
  } state_t;

  localparam logic [1:0] ENCODER_ONLY = 2'd0;
  localparam logic [1:0] DECODER_ONLY = 2'd1;
  localparam logic [1:0] FULL_CHANNEL = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_DATA_IN  = 8'h04;
  localparam logic [7:0] ADDR_CW_WIDTH = 8'h08;
  localparam logic [7:0] ADDR_NOISE    = 8'h0C;

  localparam logic [1:0] WR_DATA  = 2'd0;
  localparam logic [1:0] WR_WIDTH = 2'd1;
  localparam logic [1:0] WR_NOISE = 2'd2;
  localparam logic [1:0] WR_CTRL  = 2'd3;

  localparam logic [1:0] STATUS_OK      = 2'd0;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd1;
  localparam logic [1:0] STATUS_ILLEGAL = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr wins.
// Ports: req, ptr, en in; one-hot gnt and its idx out.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (en && !found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IW'(j);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ecc_job_sequencer.sv
// Shares the ECC APB port between requesters: arbitrates, writes the job
// registers, waits for operation_done and returns a result on res_*.
module ecc_job_sequencer
  import ecc_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYC     = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*2-1:0]          req_mode,
  input  logic [NUM_REQ*2-1:0]          req_width,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_noise,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(NUM_REQ)-1:0]    res_id,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic [1:0]                    res_errors,
  output logic [1:0]                    res_status,
  output logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
  output logic [AMBA_WORD-1:0]          PWDATA,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  input  logic                          operation_done,
  input  logic [DATA_WIDTH-1:0]         data_out,
  input  logic [1:0]                    num_of_errors
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [1:0]            widx_q, widx_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [1:0]            width_q, width_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] noise_q, noise_d;
  logic [IW-1:0]         id_q, id_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rerr_q, rerr_d;
  logic [1:0]            rstat_q, rstat_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         gidx;
  logic [1:0]            sel_mode, sel_width;
  logic [DATA_WIDTH-1:0] sel_data, sel_noise;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (state_q == ST_IDLE),
    .gnt (gnt),
    .idx (gidx)
  );

  assign req_ready  = gnt;
  assign res_valid  = (state_q == ST_RESP);
  assign res_id     = id_q;
  assign res_data   = rdata_q;
  assign res_errors = rerr_q;
  assign res_status = rstat_q;

  always_comb begin
    sel_mode  = '0;
    sel_width = '0;
    sel_data  = '0;
    sel_noise = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_mode  = req_mode[i*2 +: 2];
        sel_width = req_width[i*2 +: 2];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_noise = req_noise[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // APB outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    PSEL    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    PENABLE = (state_q == ST_ACCESS);
    PWRITE  = PSEL;
    PADDR   = '0;
    PWDATA  = '0;
    if (PSEL) begin
      unique case (widx_q)
        WR_DATA: begin
          PADDR  = AMBA_ADDR_WIDTH'(ADDR_DATA_IN);
          PWDATA = AMBA_WORD'(data_q);
        end
        WR_WIDTH: begin
          PADDR  = AMBA_ADDR_WIDTH'(ADDR_CW_WIDTH);
          PWDATA = AMBA_WORD'(width_q);
        end
        WR_NOISE: begin
          PADDR  = AMBA_ADDR_WIDTH'(ADDR_NOISE);
          PWDATA = AMBA_WORD'(noise_q);
        end
        default: begin
          PADDR  = AMBA_ADDR_WIDTH'(ADDR_CTRL);
          PWDATA = AMBA_WORD'(mode_q);
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    widx_d  = widx_q;
    tcnt_d  = tcnt_q;
    mode_d  = mode_q;
    width_d = width_q;
    data_d  = data_q;
    noise_d = noise_q;
    id_d    = id_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    rstat_d = rstat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          ptr_d   = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          id_d    = gidx;
          mode_d  = sel_mode;
          width_d = sel_width;
          data_d  = sel_data;
          noise_d = sel_noise;
          if (sel_mode == MODE_ILLEGAL) begin
            state_d = ST_RESP;
            rdata_d = '0;
            rerr_d  = '0;
            rstat_d = STATUS_ILLEGAL;
          end else begin
            state_d = ST_SETUP;
            widx_d  = WR_DATA;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (widx_q == WR_CTRL) begin
          state_d = ST_WAIT_DONE;
          tcnt_d  = '0;
        end else begin
          state_d = ST_SETUP;
          // NOISE is only programmed for the full channel.
          if (widx_q == WR_WIDTH && mode_q != FULL_CHANNEL)
            widx_d = WR_CTRL;
          else
            widx_d = widx_q + 2'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (operation_done) begin
          state_d = ST_RESP;
          rdata_d = data_out;
          rerr_d  = num_of_errors;
          rstat_d = STATUS_OK;
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = ST_RESP;
          rdata_d = '0;
          rerr_d  = '0;
          rstat_d = STATUS_TIMEOUT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_RESP: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      widx_q  <= '0;
      tcnt_q  <= '0;
      mode_q  <= '0;
      width_q <= '0;
      data_q  <= '0;
      noise_q <= '0;
      id_q    <= '0;
      rdata_q <= '0;
      rerr_q  <= '0;
      rstat_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      widx_q  <= widx_d;
      tcnt_q  <= tcnt_d;
      mode_q  <= mode_d;
      width_q <= width_d;
      data_q  <= data_d;
      noise_q <= noise_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      rstat_q <= rstat_d;
    end
  end

endmodule

// File: tb/tb_ecc_job_sequencer.sv
// Directed bench for ecc_job_sequencer with a small ECC responder model.
// Ports of the DUT are all driven or observed here.
module tb_ecc_job_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [3:0]  req_mode = '0;
  logic [3:0]  req_width = '0;
  logic [63:0] req_data = '0;
  logic [63:0] req_noise = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [0:0]  res_id;
  logic [31:0] res_data;
  logic [1:0]  res_errors;
  logic [1:0]  res_status;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic        operation_done = 1'b0;
  logic [31:0] ecc_data = '0;
  logic [1:0]  ecc_err = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ecc_delay = 1;
  bit ecc_en = 1'b1;
  int dcnt = 0;
  int psel_cnt = 0;
  int twohot = 0;

  typedef struct {
    logic [19:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t        wlog[$];
  logic [1:0] glog[$];

  always #5 clk = ~clk;

  ecc_job_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_mode       (req_mode),
    .req_width      (req_width),
    .req_data       (req_data),
    .req_noise      (req_noise),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_id         (res_id),
    .res_data       (res_data),
    .res_errors     (res_errors),
    .res_status     (res_status),
    .PADDR          (PADDR),
    .PWDATA         (PWDATA),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PWRITE         (PWRITE),
    .operation_done (operation_done),
    .data_out       (ecc_data),
    .num_of_errors  (ecc_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // ECC responder: done pulse ecc_delay cycles after the CTRL access.
  always @(posedge clk) begin
    operation_done <= 1'b0;
    if (dcnt == 1) operation_done <= 1'b1;
    if (dcnt > 0) dcnt <= dcnt - 1;
    if (ecc_en && !rst && PSEL && PENABLE && PADDR == 20'h0) begin
      if (ecc_delay == 1) operation_done <= 1'b1;
      else dcnt <= ecc_delay - 1;
    end
  end

  always @(posedge clk) begin
    if (!rst && PSEL && PENABLE) wlog.push_back('{PADDR, PWDATA});
    if (PSEL) psel_cnt <= psel_cnt + 1;
  end

  always @(negedge clk) begin
    if (|req_ready) glog.push_back(req_ready);
    if ($countones(req_ready) > 1) twohot <= twohot + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input int r, input logic [1:0] mode,
                         input logic [1:0] width, input logic [31:0] data,
                         input logic [31:0] noise,
                         output int gcyc, output int rcyc);
    wlog.delete();
    @(negedge clk);
    req_mode[r*2 +: 2]   = mode;
    req_width[r*2 +: 2]  = width;
    req_data[r*32 +: 32] = data;
    req_noise[r*32 +: 32] = noise;
    req_valid[r] = 1'b1;
    gcyc = -1;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (req_ready[r]) begin
        gcyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("grant_seen", 64'(gcyc >= 0), 64'd1);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
    rcyc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (res_valid) begin
        rcyc = cyc;
        break;
      end
    end
    check("result_seen", 64'(rcyc >= 0), 64'd1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  initial begin
    int g, r, p0, a;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_psel", 64'(PSEL), 64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_pwrite", 64'(PWRITE), 64'd0);
    check("rst_paddr", 64'(PADDR), 64'd0);
    check("rst_pwdata", 64'(PWDATA), 64'd0);
    check("rst_res_fields", {res_id, res_data, res_errors, res_status}, 64'd0);
    rst = 1'b0;

    // single encode
    ecc_data = 32'h3C5; ecc_err = 2'd0; ecc_delay = 1;
    run_job(0, 2'd0, 2'd2, 32'h1A5, 32'h0, g, r);
    check("enc_latency", 64'(r - g), 64'd8);
    check("enc_id", 64'(res_id), 64'd0);
    check("enc_status", 64'(res_status), 64'd0);
    check("enc_data", 64'(res_data), 64'h3C5);
    check("enc_errors", 64'(res_errors), 64'd0);
    check("enc_nwrites", 64'(wlog.size()), 64'd3);
    check("enc_w0", {wlog[0].a, wlog[0].d}, {20'h04, 32'h1A5});
    check("enc_w1", {wlog[1].a, wlog[1].d}, {20'h08, 32'h2});
    check("enc_w2", {wlog[2].a, wlog[2].d}, {20'h00, 32'h0});
    accept();

    // full channel
    ecc_data = 32'h5A; ecc_err = 2'd1; ecc_delay = 2;
    run_job(1, 2'd2, 2'd1, 32'h2B, 32'h4, g, r);
    check("fc_latency", 64'(r - g), 64'd11);
    check("fc_id", 64'(res_id), 64'd1);
    check("fc_status", 64'(res_status), 64'd0);
    check("fc_data", 64'(res_data), 64'h5A);
    check("fc_errors", 64'(res_errors), 64'd1);
    check("fc_nwrites", 64'(wlog.size()), 64'd4);
    check("fc_w0", {wlog[0].a, wlog[0].d}, {20'h04, 32'h2B});
    check("fc_w1", {wlog[1].a, wlog[1].d}, {20'h08, 32'h1});
    check("fc_w2", {wlog[2].a, wlog[2].d}, {20'h0C, 32'h4});
    check("fc_w3", {wlog[3].a, wlog[3].d}, {20'h00, 32'h2});
    accept();

    // contention
    ecc_delay = 1; ecc_err = 2'd0;
    @(negedge clk);
    glog.delete();
    req_mode = 4'b0000;
    res_ready = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (glog.size() >= 4) break;
    end
    req_valid = 2'b00;
    repeat (15) @(negedge clk);
    res_ready = 1'b0;
    check("cont_ngrants", 64'(glog.size()), 64'd4);
    check("cont_g0", 64'(glog[0]), 64'b01);
    check("cont_g1", 64'(glog[1]), 64'b10);
    check("cont_g2", 64'(glog[2]), 64'b01);
    check("cont_g3", 64'(glog[3]), 64'b10);
    check("cont_twohot", 64'(twohot), 64'd0);
    check("cont_idle", 64'(res_valid), 64'd0);

    // timeout
    ecc_en = 1'b0; ecc_data = 32'hFFFF; ecc_err = 2'd2;
    run_job(0, 2'd1, 2'd0, 32'h77, 32'h0, g, r);
    check("to_latency", 64'(r - g), 64'd22);
    check("to_status", 64'(res_status), 64'd1);
    check("to_data", 64'(res_data), 64'd0);
    check("to_errors", 64'(res_errors), 64'd0);
    check("to_id", 64'(res_id), 64'd0);
    accept();
    ecc_en = 1'b1;

    // illegal mode
    p0 = psel_cnt;
    run_job(1, 2'd3, 2'd0, 32'h99, 32'h0, g, r);
    check("ill_latency", 64'(r - g), 64'd1);
    check("ill_status", 64'(res_status), 64'd2);
    check("ill_data", 64'(res_data), 64'd0);
    check("ill_id", 64'(res_id), 64'd1);
    check("ill_no_psel", 64'(psel_cnt - p0), 64'd0);
    accept();

    // backpressure, then back-to-back grant
    ecc_data = 32'hABC; ecc_err = 2'd3;
    req_mode[3:2] = 2'd1;
    req_valid[1] = 1'b1;
    run_job(0, 2'd0, 2'd3, 32'h11, 32'h0, g, r);
    check("bp_id", 64'(res_id), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", {res_valid, res_data, res_errors, res_status, res_id},
            {1'b1, 32'hABC, 2'd3, 2'd0, 1'b0});
      check("bp_no_grant", 64'(req_ready), 64'd0);
    end
    a = cyc;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    check("b2b_grant", 64'(req_ready), 64'b10);
    check("b2b_cycle", 64'(cyc - a), 64'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    r = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (res_valid) begin
        r = cyc;
        break;
      end
    end
    check("b2b_result", 64'(r >= 0), 64'd1);
    check("b2b_id", 64'(res_id), 64'd1);
    accept();

    // reset during ACCESS
    ecc_delay = 2;
    @(negedge clk);
    req_mode[1:0] = 2'd2;
    req_valid[0] = 1'b1;
    a = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (req_valid[0] && !(|req_ready)) req_valid[0] = 1'b0;
      if (PSEL && PENABLE) begin
        a = 1;
        break;
      end
    end
    req_valid[0] = 1'b0;
    check("rst_reach_access", 64'(a), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_psel", 64'(PSEL), 64'd0);
    check("rst_mid_penable", 64'(PENABLE), 64'd0);
    check("rst_mid_res_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ecc_delay = 1;
    req_mode = 4'b0000;
    req_valid = 2'b11;
    #1;
    check("rst_ptr_zero", 64'(req_ready), 64'b01);
    @(posedge clk);
    #1 req_valid = 2'b00;
    r = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (res_valid) begin
        r = cyc;
        break;
      end
    end
    check("rst_job_result", 64'(r >= 0), 64'd1);
    check("rst_job_id", 64'(res_id), 64'd0);
    accept();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
